// File: rtl/vidac_blitter_if.sv
// RAM-side bus of the blitter: command enable, byte address, read data, write data and strobe.
// The blitter drives the address/write side; the RAM and command source sit on the slave side.
interface vidac_blitter_if;
    logic        cmd;
    logic [17:0] a;
    logic [7:0]  i;
    logic [7:0]  o;
    logic        w;

    modport master (
        input  cmd,
        input  i,
        output a,
        output o,
        output w
    );

    modport slave (
        output cmd,
        output i,
        input  a,
        input  o,
        input  w
    );
endinterface

// File: rtl/vidac_blitter.sv
// Command-block blitter: fetches an opcode block from RAM, fills/plots into a 320x200x8 framebuffer.
// One pixel per clock; RAM outputs decode from registered state so reset silences w at once.
module vidac_blitter (
    input  logic            clock,
    input  logic            reset,
    vidac_blitter_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

    localparam logic [17:0] CMD_BASE   = 18'h20000;
    localparam logic [7:0]  OP_NOP     = 8'h00;
    localparam logic [7:0]  OP_PSET    = 8'h01;
    localparam logic [7:0]  OP_FILL    = 8'h05;
    localparam logic [3:0]  FETCH_LAST = 4'd10;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  k_q;
    logic [7:0]  opcode_q;
    logic [7:0]  color_q;
    logic [15:0] px_q;
    logic [15:0] py_q;
    logic [15:0] pw_q;
    logic [15:0] ph_q;
    logic [15:0] dx_q;
    logic [15:0] dy_q;
    logic [16:0] x_sum;
    logic [16:0] y_sum;
    logic        visible;
    logic        row_end;
    logic        draw_last;
    logic [17:0] pix_addr;
    logic [17:0] a_c;
    logic [7:0]  o_c;
    logic        w_c;

    // Sums carry a 17th bit so coordinates past 65535 stay off-screen instead of wrapping.
    assign x_sum   = {1'b0, px_q} + {1'b0, dx_q};
    assign y_sum   = {1'b0, py_q} + {1'b0, dy_q};
    assign visible = (x_sum < 17'd320) && (y_sum < 17'd200);

    // y*320 = y*256 + y*64; only meaningful when visible, so low bits suffice.
    assign pix_addr = {2'b00, y_sum[7:0], 8'd0}
                    + {4'b0000, y_sum[7:0], 6'd0}
                    + {9'd0, x_sum[8:0]};

    assign row_end   = (({1'b0, dx_q} + 17'd1) == {1'b0, pw_q});
    assign draw_last = (opcode_q == OP_PSET) ||
                       (row_end && (({1'b0, dy_q} + 17'd1) == {1'b0, ph_q}));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_c     = 18'd0;
        o_c     = 8'd0;
        w_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                a_c = CMD_BASE + {14'd0, k_q};
                if (k_q == FETCH_LAST) begin
                    case (opcode_q)
                        OP_NOP:  state_d = IDLE;
                        OP_PSET: state_d = DRAW;
                        OP_FILL: state_d = ((pw_q == 16'd0) || (ph_q == 16'd0)) ? DONE : DRAW;
                        default: state_d = DONE;
                    endcase
                end
            end
            DRAW: begin
                a_c = pix_addr;
                o_c = color_q;
                w_c = visible;
                if (draw_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                a_c     = CMD_BASE;
                o_c     = 8'h00;
                w_c     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte k-1 of the command block arrives while k is being presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_q      <= 4'd0;
            opcode_q <= 8'd0;
            color_q  <= 8'd0;
            px_q     <= 16'd0;
            py_q     <= 16'd0;
            pw_q     <= 16'd0;
            ph_q     <= 16'd0;
        end else if (state_q == FETCH) begin
            k_q <= k_q + 4'd1;
            case (k_q)
                4'd1:    opcode_q   <= bus.i;
                4'd2:    px_q[7:0]  <= bus.i;
                4'd3:    px_q[15:8] <= bus.i;
                4'd4:    py_q[7:0]  <= bus.i;
                4'd5:    py_q[15:8] <= bus.i;
                4'd6:    pw_q[7:0]  <= bus.i;
                4'd7:    pw_q[15:8] <= bus.i;
                4'd8:    ph_q[7:0]  <= bus.i;
                4'd9:    ph_q[15:8] <= bus.i;
                4'd10:   color_q    <= bus.i;
                default: ;
            endcase
        end else begin
            k_q <= 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx_q <= 16'd0;
            dy_q <= 16'd0;
        end else if (state_q == DRAW) begin
            if (row_end) begin
                dx_q <= 16'd0;
                dy_q <= dy_q + 16'd1;
            end else begin
                dx_q <= dx_q + 16'd1;
            end
        end else begin
            dx_q <= 16'd0;
            dy_q <= 16'd0;
        end
    end

    assign bus.a = a_c;
    assign bus.o = o_c;
    assign bus.w = w_c;
endmodule

// File: tb/tb_vidac_blitter.sv
// Bench for vidac_blitter: behavioural RAM, write log, and an arithmetic model of each command.
module tb_vidac_blitter;
    logic clock;
    logic reset;
    vidac_blitter_if bus();

    vidac_blitter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:262143];
    int log_a[$];
    int log_d[$];
    int exp_a[$];
    int exp_d[$];
    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge clock) begin
        if (bus.w) mem[bus.a] <= bus.o;
        bus.i <= mem[bus.a];
    end

    always @(negedge clock) begin
        if (!reset && bus.w) begin
            log_a.push_back(int'(bus.a));
            log_d.push_back(int'(bus.o));
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_block(input int op, input int x, input int y,
                              input int wd, input int ht, input int c);
        mem[18'h20000] = op[7:0];
        mem[18'h20001] = x[7:0];
        mem[18'h20002] = x[15:8];
        mem[18'h20003] = y[7:0];
        mem[18'h20004] = y[15:8];
        mem[18'h20005] = wd[7:0];
        mem[18'h20006] = wd[15:8];
        mem[18'h20007] = ht[7:0];
        mem[18'h20008] = ht[15:8];
        mem[18'h20009] = c[7:0];
        mem[18'h2000A] = 8'hEE;
    endtask

    task automatic build_expect(input int op, input int x, input int y,
                                input int wd, input int ht, input int c);
        exp_a.delete();
        exp_d.delete();
        if (op != 0) begin
            if (op == 5) begin
                for (int yy = y; yy < y + ht; yy++) begin
                    for (int xx = x; xx < x + wd; xx++) begin
                        if (xx < 320 && yy < 200) begin
                            exp_a.push_back(yy * 320 + xx);
                            exp_d.push_back(c);
                        end
                    end
                end
            end else if (op == 1) begin
                if (x < 320 && y < 200) begin
                    exp_a.push_back(y * 320 + x);
                    exp_d.push_back(c);
                end
            end
            exp_a.push_back(32'h20000);
            exp_d.push_back(0);
        end
    endtask

    // Runs with cmd held (covers re-poll of the cleared opcode), then drops cmd and compares logs.
    task automatic finish_and_compare(input string tag, input int draw_cycles);
        int n;
        repeat (11 + draw_cycles + 40) @(negedge clock);
        bus.cmd = 1'b0;
        repeat (15) @(negedge clock);
        check_eq({tag, "_nwr"}, log_a.size(), exp_a.size());
        n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_a%0d", tag, k), log_a[k], exp_a[k]);
            check_eq($sformatf("%s_d%0d", tag, k), log_d[k], exp_d[k]);
        end
        check_eq({tag, "_opc"}, int'(mem[18'h20000]), 0);
    endtask

    task automatic run_cmd(input string tag, input int op, input int x, input int y,
                           input int wd, input int ht, input int c);
        @(negedge clock);
        load_block(op, x, y, wd, ht, c);
        build_expect(op, x, y, wd, ht, c);
        log_a.delete();
        log_d.delete();
        bus.cmd = 1'b1;
        finish_and_compare(tag, (op == 5) ? wd * ht : 1);
    endtask

    initial begin
        int op, x, y, wd, ht, c, sel;
        bus.cmd = 1'b0;
        reset   = 1'b1;
        mem[18'h20000] = 8'h00;
        repeat (3) @(negedge clock);
        check_eq("rst_a", int'(bus.a), 0);
        check_eq("rst_o", int'(bus.o), 0);
        check_eq("rst_w", int'(bus.w), 0);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check_eq("idle_nwr", log_a.size(), 0);

        run_cmd("fill_mid",  5, 160, 100, 4, 3, 8'hAA);
        run_cmd("fill_edge", 5, 318, 199, 4, 2, 8'h55);
        run_cmd("pset0",     1, 0,   0,   9, 9, 8'h7F);
        run_cmd("op09",      9, 10,  10,  4, 4, 8'h33);
        run_cmd("fill_w0",   5, 10,  10,  0, 4, 8'h44);
        run_cmd("fill_h0",   5, 10,  10,  3, 0, 8'h45);
        run_cmd("xwrap",     5, 65534, 5, 4, 1, 8'h66);
        run_cmd("ywrap",     5, 5, 65535, 2, 2, 8'h67);
        run_cmd("pset_off",  1, 320, 5,   1, 1, 8'h68);
        run_cmd("nop",       0, 3,   3,   3, 3, 8'h69);

        // Reset in the middle of a fill: w drops asynchronously, opcode stays, fill restarts.
        @(negedge clock);
        load_block(5, 10, 10, 8, 4, 8'h5A);
        log_a.delete();
        log_d.delete();
        bus.cmd = 1'b1;
        for (int n = 0; n < 60 && log_a.size() < 3; n++) @(negedge clock);
        check_eq("mid_started", (log_a.size() >= 3) ? 1 : 0, 1);
        @(posedge clock);
        #2;
        check_eq("mid_pre_w", int'(bus.w), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_w", int'(bus.w), 0);
        @(negedge clock);
        check_eq("mid_opc_kept", int'(mem[18'h20000]), 5);
        build_expect(5, 10, 10, 8, 4, 8'h5A);
        log_a.delete();
        log_d.delete();
        reset = 1'b0;
        finish_and_compare("mid_refill", 32);

        for (int it = 0; it < 20; it++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1, 2, 3: op = 5;
                4, 5:       op = 1;
                6:          op = 0;
                default:    op = $urandom_range(2, 255);
            endcase
            if (op == 5) op = 5;
            x  = ($urandom_range(0, 1) == 1) ? $urandom_range(300, 330) : $urandom_range(0, 319);
            y  = ($urandom_range(0, 1) == 1) ? $urandom_range(190, 210) : $urandom_range(0, 199);
            wd = $urandom_range(0, 6);
            ht = $urandom_range(0, 4);
            c  = $urandom_range(1, 255);
            run_cmd($sformatf("rnd%0d", it), op, x, y, wd, ht, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
